// File: rtl/move_encoder.sv
// Turns a one-hot 3x3 cell-press vector into a validated (row, column) move
// on a valid/ready handshake, tracking occupancy, turn and press errors.
module move_encoder (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic [8:0] cell_req,
  input  logic       move_ready,
  output logic [1:0] r,
  output logic [1:0] c,
  output logic       player,
  output logic       move_valid,
  output logic       err_multi,
  output logic       err_taken,
  output logic [8:0] occupied,
  output logic       full
);

  typedef enum logic [1:0] {IDLE, HOLD, WAIT_RELEASE} state_t;

  state_t     state_q, state_d;
  logic [1:0] r_q, r_d, c_q, c_d;
  logic       turn_q, turn_d;
  logic       valid_q, valid_d;
  logic       err_multi_q, err_multi_d;
  logic       err_taken_q, err_taken_d;
  logic [8:0] occ_q, occ_d;
  logic [8:0] sel_q, sel_d;

  logic [3:0] press_cnt;
  logic [1:0] pick_row, pick_col;
  logic       press_multi, press_taken;

  // Reverse of the row/column decode; only meaningful when exactly one bit is set.
  always_comb begin
    press_cnt = '0;
    pick_row  = '0;
    pick_col  = '0;
    for (int k = 0; k < 9; k++) begin
      if (cell_req[k]) begin
        press_cnt = press_cnt + 4'd1;
        pick_row  = 2'(k / 3 + 1);
        pick_col  = 2'(k % 3 + 1);
      end
    end
  end

  assign press_multi = (press_cnt > 4'd1);
  assign press_taken = |(cell_req & occ_q);

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path infers a latch.
    state_d     = state_q;
    r_d         = r_q;
    c_d         = c_q;
    turn_d      = turn_q;
    valid_d     = valid_q;
    occ_d       = occ_q;
    sel_d       = sel_q;
    err_multi_d = 1'b0;
    err_taken_d = 1'b0;

    if (clear) begin
      // Landing in WAIT_RELEASE keeps a key held across the clear from being captured.
      state_d = WAIT_RELEASE;
      r_d     = '0;
      c_d     = '0;
      turn_d  = 1'b0;
      valid_d = 1'b0;
      occ_d   = '0;
      sel_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (press_multi) begin
            err_multi_d = 1'b1;
            state_d     = WAIT_RELEASE;
          end else if (press_taken) begin
            err_taken_d = 1'b1;
            state_d     = WAIT_RELEASE;
          end else if (press_cnt == 4'd1) begin
            r_d     = pick_row;
            c_d     = pick_col;
            sel_d   = cell_req;
            valid_d = 1'b1;
            state_d = HOLD;
          end
        end
        HOLD: begin
          if (move_ready) begin
            occ_d   = occ_q | sel_q;
            turn_d  = ~turn_q;
            valid_d = 1'b0;
            state_d = WAIT_RELEASE;
          end
        end
        WAIT_RELEASE: begin
          if (cell_req == 9'h000) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      r_q         <= '0;
      c_q         <= '0;
      turn_q      <= 1'b0;
      valid_q     <= 1'b0;
      err_multi_q <= 1'b0;
      err_taken_q <= 1'b0;
      occ_q       <= '0;
      sel_q       <= '0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      c_q         <= c_d;
      turn_q      <= turn_d;
      valid_q     <= valid_d;
      err_multi_q <= err_multi_d;
      err_taken_q <= err_taken_d;
      occ_q       <= occ_d;
      sel_q       <= sel_d;
    end
  end

  // The turn register doubles as the presented mover: it only changes at a handshake.
  assign r          = r_q;
  assign c          = c_q;
  assign player     = turn_q;
  assign move_valid = valid_q;
  assign err_multi  = err_multi_q;
  assign err_taken  = err_taken_q;
  assign occupied   = occ_q;
  assign full       = &occ_q;

endmodule

// File: tb/tb_move_encoder.sv
// Self-checking bench for move_encoder: directed scenarios plus random presses,
// all compared against an event-level model of the press/move rules.
module tb_move_encoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  logic [8:0] cell_req = '0;
  logic       move_ready = 1'b0;
  logic [1:0] r, c;
  logic       player, move_valid, err_multi, err_taken, full;
  logic [8:0] occupied;

  int n_compared = 0;
  int n_mismatched = 0;

  // Model: a press is taken only when "armed" (key released since the last event).
  bit       m_armed, m_pending;
  int       m_cell;
  int       m_r, m_c, m_turn;
  bit       m_em, m_et;
  bit [8:0] m_occ;

  move_encoder dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .cell_req(cell_req),
    .move_ready(move_ready), .r(r), .c(c), .player(player),
    .move_valid(move_valid), .err_multi(err_multi), .err_taken(err_taken),
    .occupied(occupied), .full(full)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_armed = 1; m_pending = 0; m_cell = 0;
    m_r = 0; m_c = 0; m_turn = 0; m_em = 0; m_et = 0; m_occ = '0;
  endtask

  task automatic model_step(input logic [8:0] req, input logic rdy, input logic clr);
    int ones, idx;
    ones = 0; idx = 0;
    for (int i = 0; i < 9; i++) if (req[i]) begin ones++; idx = i; end
    m_em = 0; m_et = 0;
    if (clr) begin
      m_occ = '0; m_turn = 0; m_pending = 0; m_r = 0; m_c = 0; m_armed = 0;
    end else if (m_pending) begin
      if (rdy) begin
        m_occ[m_cell] = 1'b1;
        m_turn = 1 - m_turn;
        m_pending = 0;
        m_armed = 0;
      end
    end else if (!m_armed) begin
      if (ones == 0) m_armed = 1;
    end else if (ones >= 2) begin
      m_em = 1; m_armed = 0;
    end else if (ones == 1 && m_occ[idx]) begin
      m_et = 1; m_armed = 0;
    end else if (ones == 1) begin
      m_pending = 1; m_cell = idx; m_r = idx / 3 + 1; m_c = idx % 3 + 1;
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".r"}, 32'(r), 32'(m_r));
    check({tag, ".c"}, 32'(c), 32'(m_c));
    check({tag, ".player"}, 32'(player), 32'(m_turn));
    check({tag, ".valid"}, 32'(move_valid), 32'(m_pending));
    check({tag, ".err_multi"}, 32'(err_multi), 32'(m_em));
    check({tag, ".err_taken"}, 32'(err_taken), 32'(m_et));
    check({tag, ".occupied"}, 32'(occupied), 32'(m_occ));
    check({tag, ".full"}, 32'(full), 32'(m_occ == 9'h1FF));
  endtask

  // Inputs are applied 1 time unit after an edge, sampled on the next edge,
  // and outputs are compared 1 time unit after that edge.
  task automatic step(input string tag, input logic [8:0] req, input logic rdy, input logic clr);
    cell_req = req; move_ready = rdy; clear = clr;
    @(posedge clk);
    #1;
    model_step(req, rdy, clr);
    compare_all(tag);
  endtask

  initial begin
    model_reset();
    #1;
    compare_all("reset");
    @(negedge clk); rst_n = 1'b1;

    // Reset mid-HOLD with cell 4 pending.
    step("rst_hold", 9'h010, 1'b0, 1'b0);
    check("rst_hold.pre_valid", 32'(move_valid), 32'd1);
    #2; rst_n = 1'b0; cell_req = '0;
    #1;
    model_reset();
    compare_all("async_rst");
    @(negedge clk); rst_n = 1'b1;
    step("after_rst", 9'h000, 1'b0, 1'b0);
    check("after_rst.occ", 32'(occupied), 32'h000);

    // Basic move on cell 4 with ready held high.
    step("basic_cap", 9'h010, 1'b1, 1'b0);
    check("basic.r", 32'(r), 32'd2);
    check("basic.c", 32'(c), 32'd2);
    check("basic.player", 32'(player), 32'd0);
    step("basic_hs", 9'h010, 1'b1, 1'b0);
    check("basic.occ", 32'(occupied), 32'h010);
    step("basic_rel", 9'h000, 1'b0, 1'b0);

    // Taken cell: cell 4 again.
    step("taken", 9'h010, 1'b0, 1'b0);
    check("taken.pulse", 32'(err_taken), 32'd1);
    check("taken.player", 32'(player), 32'd1);
    step("taken_hold", 9'h010, 1'b0, 1'b0);
    check("taken.one_cycle", 32'(err_taken), 32'd0);
    step("taken_rel", 9'h000, 1'b0, 1'b0);

    // Backpressure on a fresh board.
    step("bp_clr", 9'h000, 1'b0, 1'b1);
    step("bp_arm", 9'h000, 1'b0, 1'b0);
    step("bp_cap", 9'h001, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step("bp_wait", 9'h100, 1'b0, 1'b0);
    check("bp.r", 32'(r), 32'd1);
    check("bp.c", 32'(c), 32'd1);
    step("bp_hs", 9'h100, 1'b1, 1'b0);
    check("bp.occ", 32'(occupied), 32'h001);
    step("bp_rel", 9'h000, 1'b0, 1'b0);

    // Multi-press held four cycles, then a clean single press.
    for (int i = 0; i < 4; i++) step("multi", 9'h003, 1'b0, 1'b0);
    step("multi_rel", 9'h000, 1'b0, 1'b0);
    step("multi_next", 9'h002, 1'b0, 1'b0);
    check("multi_next.c", 32'(c), 32'd2);
    step("multi_hs", 9'h002, 1'b1, 1'b0);
    step("multi_rel2", 9'h000, 1'b0, 1'b0);

    // Full board in order 0..8, tenth press, then clear with a key held.
    step("full_clr", 9'h000, 1'b0, 1'b1);
    step("full_arm", 9'h000, 1'b0, 1'b0);
    for (int k = 0; k < 9; k++) begin
      logic [8:0] key;
      key = 9'(1 << k);
      step("full_cap", key, 1'b0, 1'b0);
      check("full.player", 32'(player), 32'(k % 2));
      step("full_hs", key, 1'b1, 1'b0);
      step("full_rel", 9'h000, 1'b0, 1'b0);
    end
    check("full.flag", 32'(full), 32'd1);
    step("tenth", 9'h020, 1'b0, 1'b0);
    check("tenth.err_taken", 32'(err_taken), 32'd1);
    step("clr_held", 9'h010, 1'b0, 1'b1);
    check("clr.occ", 32'(occupied), 32'h000);
    step("clr_still", 9'h010, 1'b1, 1'b0);
    check("clr.no_move", 32'(move_valid), 32'd0);
    step("clr_rel", 9'h000, 1'b0, 1'b0);
    step("clr_press", 9'h010, 1'b0, 1'b0);
    check("clr.move", 32'(move_valid), 32'd1);

    // Random presses held for random lengths, random backpressure, rare clears.
    for (int n = 0; n < 600; n++) begin
      logic [8:0] key;
      int hold, kind;
      kind = $urandom_range(0, 9);
      if (kind < 2)      key = '0;
      else if (kind < 4) key = 9'($urandom_range(0, 511));
      else               key = 9'(1 << $urandom_range(0, 8));
      hold = $urandom_range(1, 6);
      for (int h = 0; h < hold; h++)
        step("rand", key, 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 60) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
